// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the load path: funct3 load encodings, load FSM states
// and small decode helpers.
package rv32i_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WB
  } ld_state_e;

  function automatic logic funct3_legal(input logic [2:0] f3);
    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

  function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LH, F3_LHU: return off[0];
      F3_LW:         return off != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane extraction and sign/zero extension of a loaded memory word.
module load_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (byte_off)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = byte_off[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   data = {{16{half_lane[15]}}, half_lane};
      F3_LBU:  data = {24'h0, byte_lane};
      F3_LHU:  data = {16'h0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_wb_unit.sv
// RV32I load unit: accepts a load, reads memory with timeout, aligns and writes back.
// Optional LOAD_MISALIGN_CHECK_EN rejects misaligned LH/LHU/LW in IDLE.
module load_wb_unit
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_funct3,
  input  logic [4:0]  ld_rd,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rf_write,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        busy,
  output logic        ld_err
);

  // Last WAIT cycle index: the unit waits at most TIMEOUT_CYCLES cycles.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  ld_state_e   state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic [7:0]  tmo_q;
  logic [31:0] wd_q;
  logic        err_q, err_d;
  logic        accept;
  logic        cmd_bad;
  logic [31:0] aligned;

  load_align u_align (
    .funct3   (funct3_q),
    .byte_off (addr_q[1:0]),
    .rdata    (mem_rdata),
    .data     (aligned)
  );

  always_comb begin
    cmd_bad = !funct3_legal(ld_funct3);
`ifdef LOAD_MISALIGN_CHECK_EN
    cmd_bad = cmd_bad || load_misaligned(ld_funct3, ld_addr[1:0]);
`endif
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ld_valid) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ:  if (mem_gnt) state_d = ST_WAIT;
      ST_WAIT: begin
        // Data arriving on the final WAIT cycle takes priority over the timeout.
        if (mem_rvalid) begin
          state_d = ST_WB;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the write-data register is reset too, so no stale load result survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      tmo_q    <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q   <= ld_addr;
        funct3_q <= ld_funct3;
        rd_q     <= ld_rd;
      end
      if (state_q == ST_REQ) begin
        tmo_q <= '0;
      end else if (state_q == ST_WAIT) begin
        tmo_q <= tmo_q + 8'd1;
      end
      if (state_q == ST_WAIT && mem_rvalid) begin
        wd_q <= aligned;
      end
    end
  end

  assign ld_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign mem_req  = (state_q == ST_REQ);
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign rf_write = (state_q == ST_WB) && (rd_q != 5'd0);
  assign rf_wa    = rd_q;
  assign rf_wd    = wd_q;
  assign ld_err   = err_q;

endmodule

// File: tb/tb_load_wb_unit.sv
// Self-checking bench for load_wb_unit: directed cases plus randomized loads against
// an arithmetic reference model. Honours LOAD_MISALIGN_CHECK_EN like the design.
module tb_load_wb_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic [4:0]  ld_rd;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_write;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        busy;
  logic        ld_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_wb_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_funct3  (ld_funct3),
    .ld_rd      (ld_rd),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rf_write   (rf_write),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .busy       (busy),
    .ld_err     (ld_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_data(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * a[1:0])) & 32'hFF;
    h = (d >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  function automatic bit exp_reject(input logic [2:0] f3, input logic [31:0] a);
    bit illegal;
    bit misal;
    illegal = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal   = (f3 == 3'b010 && a[1:0] != 2'b00) || ((f3 == 3'b001 || f3 == 3'b101) && a[0]);
`ifdef LOAD_MISALIGN_CHECK_EN
    return illegal || misal;
`else
    return illegal && (misal || !misal);
`endif
  endfunction

  // Issues one load starting just after a clock edge with the unit idle.
  task automatic run_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] d, input int gnt_delay, input int rv_delay);
    logic [31:0] exp_addr;
    exp_addr = {a[31:2], 2'b00};
    check("idle_ready", ld_ready, 1);
    ld_valid = 1'b1; ld_addr = a; ld_funct3 = f3; ld_rd = rd;
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_addr = $urandom; ld_funct3 = 3'($urandom); ld_rd = 5'($urandom);
    if (exp_reject(f3, a)) begin
      check("reject_err", ld_err, 1);
      check("reject_no_req", mem_req, 0);
      check("reject_ready", ld_ready, 1);
      @(posedge clk); #1;
      check("reject_err_pulse", ld_err, 0);
      return;
    end
    for (int i = 0; i <= gnt_delay; i++) begin
      check("req_held", mem_req, 1);
      check("req_addr", mem_addr, exp_addr);
      check("req_not_ready", ld_ready, 0);
      mem_gnt    = (i == gnt_delay);
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    for (int i = 0; i < T; i++) begin
      check("wait_no_req", mem_req, 0);
      check("wait_no_write", rf_write, 0);
      check("wait_no_err", ld_err, 0);
      check("wait_busy", busy, 1);
      if (i == rv_delay) begin
        mem_rvalid = 1'b1; mem_rdata = d;
      end else begin
        mem_rdata = $urandom;
      end
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      if (i == rv_delay) break;
    end
    if (rv_delay < T) begin
      check("wb_write", rf_write, (rd != 5'd0));
      check("wb_wa", rf_wa, rd);
      check("wb_wd", rf_wd, ref_data(f3, a, d));
      check("wb_no_err", ld_err, 0);
      mem_rvalid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      check("after_wb_no_write", rf_write, 0);
      check("after_wb_ready", ld_ready, 1);
    end else begin
      check("tmo_err", ld_err, 1);
      check("tmo_no_write", rf_write, 0);
      check("tmo_ready", ld_ready, 1);
      @(posedge clk); #1;
      check("tmo_err_pulse", ld_err, 0);
      check("tmo_still_no_write", rf_write, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0; ld_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_rf_write", rf_write, 0);
    check("rst_ld_err", ld_err, 0);
    check("rst_rf_wd", rf_wd, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_ready", ld_ready, 1);

    run_load(32'h0000_0103, 3'b000, 5'd5, 32'h80FF_FF7F, 0, 0);
    run_load(32'h0000_0102, 3'b101, 5'd9, 32'hBEEF_1234, 0, 0);
    run_load(32'h0000_0102, 3'b001, 5'd9, 32'hBEEF_1234, 0, 1);
    run_load(32'h0000_2000, 3'b010, 5'd3, 32'h1234_5678, 3, 0);
    run_load(32'h0000_3004, 3'b010, 5'd4, 32'hCAFE_F00D, 0, T);
    run_load(32'h0000_3008, 3'b100, 5'd6, 32'h00A5_0000, 1, T - 1);
    run_load(32'h0000_4000, 3'b010, 5'd0, 32'hDEAD_BEEF, 0, 0);
    run_load(32'h0000_4000, 3'b011, 5'd8, 32'h0, 0, 0);
    run_load(32'h0000_0101, 3'b010, 5'd2, 32'h0BAD_C0DE, 0, 0);
    run_load(32'h0000_0103, 3'b001, 5'd2, 32'h8001_7F02, 0, 0);

    // Reset during WAIT, then a late rvalid must not write anything.
    ld_valid = 1'b1; ld_addr = 32'h0000_5000; ld_funct3 = 3'b010; ld_rd = 5'd7;
    @(posedge clk); #1;
    ld_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(posedge clk); #1;
    check("mid_wait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_write", rf_write, 0);
    check("mid_rst_wd", rf_wd, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("late_rvalid_no_write", rf_write, 0);
    check("late_rvalid_idle", ld_ready, 1);
    @(posedge clk); #1;
    check("late_rvalid_no_write2", rf_write, 0);
    check("late_rvalid_wd", rf_wd, 0);

    for (int n = 0; n < 60; n++) begin
      run_load($urandom, 3'($urandom), 5'($urandom), $urandom,
               int'($urandom_range(0, 3)), int'($urandom_range(0, T + 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_wb_unit.md
LOAD_WB_UNIT -- requirements
Module: load_wb_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: the maximum number of cycles spent in WAIT before the load is abandoned; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ld_valid  input  1  load command valid.
REQ-005 ld_ready  output  1  unit can accept a command; high only in IDLE.
REQ-006 ld_addr  input  32  byte address of the load.
REQ-007 ld_funct3  input  3  RV32I load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
REQ-008 ld_rd  input  5  destination register index.
REQ-009 mem_req  output  1  memory read request.
REQ-010 mem_gnt  input  1  memory accepts the request.
REQ-011 mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-012 mem_rvalid  input  1  read data valid.
REQ-013 mem_rdata  input  32  read data.
REQ-014 rf_write  output  1  register-file write strobe.
REQ-015 rf_wa  output  5  register-file write address.
REQ-016 rf_wd  output  32  register-file write data.
REQ-017 busy  output  1  high whenever the state is not IDLE.
REQ-018 ld_err  output  1  one-cycle error pulse.

Function
REQ-019 The FSM SHALL have four states: IDLE, REQ, WAIT and WB.
REQ-020 In IDLE, ld_valid with a legal funct3 SHALL latch addr, funct3 and rd, then move to REQ on the next edge.
REQ-021 An illegal funct3 (011, 110, 111) SHALL pulse ld_err for one cycle, issue no memory access and stay in IDLE.
REQ-022 In REQ, mem_req SHALL be held high with a stable mem_addr until mem_gnt is seen, then the FSM SHALL move to WAIT.
REQ-023 In WAIT, mem_rvalid SHALL capture mem_rdata and move to WB; mem_rvalid in any other state SHALL be ignored.
REQ-024 The timeout counter SHALL clear on entry to WAIT and increment each cycle in WAIT.
REQ-025 When the timeout count reaches TIMEOUT_CYCLES without mem_rvalid, the unit SHALL pulse ld_err, return to IDLE and perform no write.
REQ-026 If mem_rvalid arrives in the same cycle the timeout count reaches TIMEOUT_CYCLES, the data SHALL win and no error is raised.
REQ-027 In WB, rf_write SHALL be high for exactly one cycle with rf_wa = latched rd, then the FSM SHALL return to IDLE.
REQ-028 When the latched rd is 0, rf_write SHALL stay low in WB.
REQ-029 Byte lane select SHALL be addr[1:0] for LB/LBU; halfword lane select SHALL be addr[1] for LH/LHU.
REQ-030 LB and LH SHALL sign-extend to 32 bits, LBU and LHU SHALL zero-extend, and LW SHALL pass the word through unchanged.
REQ-031 Minimum latency SHALL be 4 cycles from accept to rf_write (accept, REQ with gnt, WAIT with rvalid, WB).
REQ-032 Back-to-back commands SHALL be possible: ld_ready rises in the cycle after WB.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE and clear the counter, all latched fields and rf_wd.
REQ-034 During reset, mem_req, rf_write and ld_err SHALL be 0, and ld_ready SHALL be 1 once rst_n is high.
REQ-035 Reset in the middle of a load SHALL abandon it with no write; a later mem_rvalid SHALL be ignored.

Configuration
REQ-036 When LOAD_MISALIGN_CHECK_EN is defined, LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, SHALL pulse ld_err in IDLE with no memory access.
REQ-037 When LOAD_MISALIGN_CHECK_EN is not defined, no misalignment check SHALL be made: LW SHALL ignore addr[1:0] and LH/LHU SHALL use addr[1] only.

Structure
REQ-038 The funct3 load encodings and the FSM state enum SHALL live in the shared rv32i package.
REQ-039 The extraction and extension logic SHALL be the combinational sub-module load_align.

Verification
REQ-040 LB at addr 0x103 with rdata 0x80FF_FF7F and rd=5 -> rf_write with wa=5 and wd=0xFFFF_FF80.
REQ-041 LHU at addr 0x102 with rdata 0xBEEF_1234 -> wd=0x0000_BEEF; LH at the same address -> wd=0xFFFF_BEEF.
REQ-042 mem_gnt delayed 3 cycles -> mem_req held for 4 cycles with a stable mem_addr, then one write.
REQ-043 TIMEOUT_CYCLES=4 with no rvalid -> ld_err pulse, no rf_write, ld_ready high again.
REQ-044 LW with rd=0 -> memory access occurs, rf_write stays low; funct3=011 -> ld_err only.
REQ-045 rst_n low while in WAIT, then rvalid arrives -> no rf_write; with LOAD_MISALIGN_CHECK_EN defined, LW at addr 0x101 -> ld_err and no mem_req.
